// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU: function-select encoding and serial FSM states.
package alu_pkg;

    localparam int unsigned ALU_SEL_W = 2;

    typedef enum logic [ALU_SEL_W-1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_ADD = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } ser_state_e;

endpackage

// File: rtl/alu_bit_slice.sv
// One-bit ALU slice: builds the four candidate bits c0..c3 and picks one via
// the 4:1 function-select mux; also produces the ripple carry for ADD.
module alu_mux4 (
    input  logic i_c0,
    input  logic i_c1,
    input  logic i_c2,
    input  logic i_c3,
    input  logic i_sel0,
    input  logic i_sel1,
    output logic o_y_c
);
    always_comb begin
        o_y_c = i_c0;
        case ({i_sel1, i_sel0})
            2'b00:   o_y_c = i_c0;
            2'b01:   o_y_c = i_c1;
            2'b10:   o_y_c = i_c2;
            default: o_y_c = i_c3;
        endcase
    end
endmodule

module alu_bit_slice
    import alu_pkg::*;
(
    input  logic                 i_a0,
    input  logic                 i_b0,
    input  logic                 i_cin,
    input  logic [ALU_SEL_W-1:0] i_op,
    output logic                 o_bit_c,
    output logic                 o_cout_c
);
    logic w_c0;
    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign w_c0 = i_a0 & i_b0;
    assign w_c1 = i_a0 | i_b0;
    assign w_c2 = i_a0 ^ i_b0;
    assign w_c3 = i_a0 ^ i_b0 ^ i_cin;

    alu_mux4 u_mux (
        .i_c0   (w_c0),
        .i_c1   (w_c1),
        .i_c2   (w_c2),
        .i_c3   (w_c3),
        .i_sel0 (i_op[0]),
        .i_sel1 (i_op[1]),
        .o_y_c  (o_bit_c)
    );

    // Carry only propagates for ADD so logic ops always finish with carry=0.
    assign o_cout_c = (i_op == OP_ADD) ?
                      ((i_a0 & i_b0) | (i_a0 & i_cin) | (i_b0 & i_cin)) : 1'b0;
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU control: accepts {a,b,op}, streams LSB-first through alu_bit_slice,
// presents the assembled result over valid/ready. Optional zero flag: ALU_SERIAL_ZERO_FLAG_EN.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALU_SEL_W-1:0] op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 carry,
    output logic                 busy
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    ,
    output logic                 zero
`endif
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    ser_state_e           r_state;
    ser_state_e           w_nxt_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     w_nxt_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     w_nxt_b;
    logic [WIDTH-1:0]     r_result;
    logic [WIDTH-1:0]     w_nxt_result;
    logic [ALU_SEL_W-1:0] r_op;
    logic [ALU_SEL_W-1:0] w_nxt_op;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_nxt_cnt;
    logic                 r_carry;
    logic                 w_nxt_carry;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
    logic                 w_bit;
    logic                 w_cout;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic                 r_zero;
    logic                 w_nxt_zero;
`endif

    alu_bit_slice u_slice (
        .i_a0     (r_a[0]),
        .i_b0     (r_b[0]),
        .i_cin    (r_carry),
        .i_op     (r_op),
        .o_bit_c  (w_bit),
        .o_cout_c (w_cout)
    );

    // Next-state and datapath update.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_a      = r_a;
        w_nxt_b      = r_b;
        w_nxt_result = r_result;
        w_nxt_op     = r_op;
        w_nxt_cnt    = r_cnt;
        w_nxt_carry  = r_carry;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        w_nxt_zero   = r_zero;
`endif
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nxt_state = RUN;
                    w_nxt_a     = a;
                    w_nxt_b     = b;
                    w_nxt_op    = op;
                    w_nxt_cnt   = '0;
                    w_nxt_carry = 1'b0;
                end
            end
            RUN: begin
                w_nxt_result = {w_bit, r_result[WIDTH-1:1]};
                w_nxt_a      = r_a >> 1;
                w_nxt_b      = r_b >> 1;
                w_nxt_carry  = w_cout;
                w_nxt_cnt    = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_nxt_state = DONE;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
                    w_nxt_zero  = (w_nxt_result == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nxt_state = IDLE;
                end
            end
            default: begin
                w_nxt_state = IDLE;
            end
        endcase
    end

    // Handshake/status flags are registered off the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            r_zero      <= 1'b0;
`endif
        end else begin
            r_state     <= w_nxt_state;
            r_a         <= w_nxt_a;
            r_b         <= w_nxt_b;
            r_result    <= w_nxt_result;
            r_op        <= w_nxt_op;
            r_cnt       <= w_nxt_cnt;
            r_carry     <= w_nxt_carry;
            r_in_ready  <= (w_nxt_state == IDLE);
            r_out_valid <= (w_nxt_state == DONE);
            r_busy      <= (w_nxt_state == RUN);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
            r_zero      <= w_nxt_zero;
`endif
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign result    = r_result;
    assign carry     = r_carry;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    assign zero      = r_zero;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_alu_serial_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [1:0]       op        = 2'b00;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             in_ready;
    logic             out_valid;
    logic             carry;
    logic             busy;
    logic [WIDTH-1:0] result;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    logic             zero;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .busy      (busy)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {carry, result} from plain word-level arithmetic.
    function automatic logic [WIDTH:0] ref_alu(input logic [1:0] f, input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        case (f)
            2'd0:    return {1'b0, x & y};
            2'd1:    return {1'b0, x | y};
            2'd2:    return {1'b0, x ^ y};
            default: return {1'b0, x} + {1'b0, y};
        endcase
    endfunction

    // Present a request and hold it until accepted; scrambles inputs afterwards.
    task automatic send(input logic [1:0] f, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        output bit accepted);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        op = f;
        a = x;
        b = y;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        accepted = in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 2'($urandom);
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
    endtask

    // Count edges after acceptance until out_valid is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (result !== 8'h00) $display("FAIL reset_result got %h want 00", result); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL reset_carry got %b want 0", carry); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        n_checks++; if (zero !== 1'b0) $display("FAIL reset_zero got %b want 0", zero); else n_pass++;
`endif
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    // Full transaction with the given op/operands; checks latency and result.
    task automatic run_and_check(input string name, input logic [1:0] f, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, input int hold);
        bit acc;
        int lat;
        logic [WIDTH:0] exp;
        exp = ref_alu(f, x, y);
        send(f, x, y, acc);
        n_checks++; if (!acc) $display("FAIL %s_accept got in_ready=0 want 1", name); else n_pass++;
        wait_done(lat);
        n_checks++; if (lat != 8) $display("FAIL %s_latency got %0d want 8", name, lat); else n_pass++;
        repeat (hold) @(negedge clk);
        n_checks++; if (result !== exp[WIDTH-1:0]) $display("FAIL %s_result got %h want %h", name, result, exp[WIDTH-1:0]); else n_pass++;
        n_checks++; if (carry !== exp[WIDTH]) $display("FAIL %s_carry got %b want %b", name, carry, exp[WIDTH]); else n_pass++;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        n_checks++; if (zero !== (exp[WIDTH-1:0] == '0)) $display("FAIL %s_zero got %b want %b", name, zero, exp[WIDTH-1:0] == '0); else n_pass++;
`endif
        consume();
    endtask

    task automatic test_add();
        run_and_check("add_0f_01", 2'b11, 8'h0F, 8'h01, 0);
        run_and_check("add_ff_01", 2'b11, 8'hFF, 8'h01, 0);
    endtask

    task automatic test_logic();
        run_and_check("and_aa_f0", 2'b00, 8'hAA, 8'hF0, 0);
        run_and_check("or_aa_f0",  2'b01, 8'hAA, 8'hF0, 0);
        run_and_check("xor_aa_f0", 2'b10, 8'hAA, 8'hF0, 0);
    endtask

    task automatic test_backpressure();
        bit acc;
        int lat;
        logic [WIDTH:0] exp;
        exp = ref_alu(2'b11, 8'hC3, 8'h5A);
        send(2'b11, 8'hC3, 8'h5A, acc);
        n_checks++; if (!acc) $display("FAIL bp_accept got in_ready=0 want 1"); else n_pass++;
        wait_done(lat);
        n_checks++; if (lat != 8) $display("FAIL bp_latency got %0d want 8", lat); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            if (i == 2) begin
                a = 8'h11;
                b = 8'h22;
                op = 2'b01;
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b want 1", i, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); else n_pass++;
            n_checks++; if (result !== exp[WIDTH-1:0]) $display("FAIL bp_result[%0d] got %h want %h", i, result, exp[WIDTH-1:0]); else n_pass++;
            n_checks++; if (carry !== exp[WIDTH]) $display("FAIL bp_carry[%0d] got %b want %b", i, carry, exp[WIDTH]); else n_pass++;
        end
        consume();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_idle_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_no_phantom_busy got %b want 0", busy); else n_pass++;
        run_and_check("bp_next", 2'b10, 8'h11, 8'h3C, 0);
    endtask

    task automatic test_mid_reset();
        bit acc;
        send(2'b11, 8'h33, 8'h44, acc);
        n_checks++; if (!acc) $display("FAIL mrst_accept got in_ready=0 want 1"); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) $display("FAIL mrst_busy_before got %b want 1", busy); else n_pass++;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL mrst_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mrst_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL mrst_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (result !== 8'h00) $display("FAIL mrst_result got %h want 00", result); else n_pass++;
        n_checks++; if (carry !== 1'b0) $display("FAIL mrst_carry got %b want 0", carry); else n_pass++;
        rst_n = 1'b1;
        run_and_check("mrst_after", 2'b11, 8'h01, 8'h02, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]       qf [4];
        logic [WIDTH-1:0] qa [4];
        logic [WIDTH-1:0] qb [4];
        logic [WIDTH:0]   exp;
        int acc_cyc [4];
        int n_acc = 0;
        int n_res = 0;
        int cyc = 0;
        for (int i = 0; i < 4; i++) begin
            qf[i] = 2'(i + 1);
            qa[i] = WIDTH'($urandom);
            qb[i] = WIDTH'($urandom);
            acc_cyc[i] = 0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = qf[0];
        a = qa[0];
        b = qb[0];
        while (n_res < 4 && cyc < 200) begin
            bit take;
            take = in_valid && in_ready;
            if (out_valid) begin
                exp = ref_alu(qf[n_res], qa[n_res], qb[n_res]);
                n_checks++; if (result !== exp[WIDTH-1:0]) $display("FAIL b2b_result[%0d] got %h want %h", n_res, result, exp[WIDTH-1:0]); else n_pass++;
                n_checks++; if (carry !== exp[WIDTH]) $display("FAIL b2b_carry[%0d] got %b want %b", n_res, carry, exp[WIDTH]); else n_pass++;
                n_res++;
            end
            @(posedge clk);
            cyc++;
            #1;
            if (take) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc < 4) begin
                    op = qf[n_acc];
                    a = qa[n_acc];
                    b = qb[n_acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (n_res != 4) $display("FAIL b2b_count got %0d want 4", n_res); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (acc_cyc[i] - acc_cyc[i-1] != 10) $display("FAIL b2b_spacing[%0d] got %0d want 10", i, acc_cyc[i] - acc_cyc[i-1]); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_and_check("rand", 2'($urandom), WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)));
        end
        run_and_check("rand_zero", 2'b11, 8'h80, 8'h80, 2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
